sparc_exu_byp_eccchk: RTL and testbench
=======================================

SPARC_EXU_BYP_ECCCHK -- requirements
Module: sparc_exu_byp_eccchk

Interface
REQ-001 clk  input  1  block clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; asynchronous, active-high.
REQ-003 in_vld  input  1  din/cin valid this cycle.
REQ-004 din  input  64  received data word.
REQ-005 cin  input  8  received check bits.
REQ-006 log_clr  input  1  clears error log.
REQ-007 cnt_clr  input  1  clears both error counters.
REQ-008 out_vld  output  1  dout/syn/ce/ue valid.
REQ-009 dout  output  64  corrected data.
REQ-010 syn  output  8  syndrome {s7, s[6:0]}.
REQ-011 ce  output  1  correctable (single-bit) error on this word.
REQ-012 ue  output  1  uncorrectable error on this word.
REQ-013 ce_cnt  output  8  saturating correctable-error count.
REQ-014 ue_cnt  output  8  saturating uncorrectable-error count.
REQ-015 log_vld, log_ue, log_syn[7:0]  output  1/1/8  first-error log: valid, type, syndrome.

Function
REQ-016 Code SHALL be the team's 64/8 SEC-DED Hamming code: data bit di occupies the (i+1)-th integer >=3 that is not a power of two (d0=3, d1=5, d2=6, d3=7, d4=9, d11=17, d26=33, d56=63, d57=65, d63=71).
REQ-017 Generated p[k], k=0..6: XOR of all di whose position has bit k set.
REQ-018 Generated p[7]: XOR of all di whose position has even popcount (overall codeword parity).
REQ-019 s[6:0] = p[6:0] ^ cin[6:0]; s7 = p[7] ^ cin[7].
REQ-020 Stage 1 registers din, in_vld and the syndrome; it may split the parity trees into registered partial XORs provided the total latency is unchanged.
REQ-021 Stage 2 registers dout, syn, ce, ue and out_vld; out_vld equals in_vld delayed exactly 2 cycles. One word is accepted per cycle, with no backpressure.
REQ-022 Classification:
- s==0 -> ce=0, ue=0, dout=din.
- s7=1 and s[6:0]==0 -> ce=1 (cin[7] error), dout=din.
- s7=1 and s[6:0] a power of two -> ce=1 (check-bit error), dout=din.
- s7=1 and s[6:0] a valid data position (3..71, not a power of two) -> ce=1, dout=din with the mapped bit inverted.
- s7=1 and s[6:0] >71 -> ue=1, dout=din.
- s7=0 and s[6:0]!=0 -> ue=1, dout=din.
REQ-023 ce and ue SHALL be mutually exclusive, and SHALL be 0 whenever out_vld=0. dout and syn are don't-care when out_vld=0.
REQ-024 ce_cnt increments on each out_vld&ce, ue_cnt on each out_vld&ue; both saturate at 255 with no wrap.
REQ-025 cnt_clr zeroes both counters next cycle. When cnt_clr coincides with an increment, the affected counter becomes 1.
REQ-026 Log: when log_vld=0 and out_vld&(ce|ue), load log_syn=syn and log_ue=ue, and set log_vld=1. Later errors do not overwrite the log while log_vld=1.
REQ-027 log_clr clears log_vld. When log_clr coincides with an error, the log loads that error (log_vld stays 1).

Reset
REQ-028 rst asserted: all pipeline valids, out_vld, ce, ue, counters, log_vld, log_ue, log_syn and dout go to 0 immediately; syn goes to 0.
REQ-029 Words in flight when rst asserts are discarded and produce no out_vld after rst deasserts.
REQ-030 The first word is accepted on the first rising edge with rst low.

Verification
REQ-031 din=0, cin=0x00, in_vld=1 -> two cycles later out_vld=1, syn=0x00, ce=0, ue=0, dout=0.
REQ-032 din=0x1 (d0 flipped), cin=0 -> syn=0x83, ce=1, dout=0, ce_cnt=1, log_vld=1, log_syn=0x83, log_ue=0.
REQ-033 din=0x8000000000000000, cin=0 -> syn=0xC7, ce=1, dout=0.
REQ-034 din=0x3 (d0 and d1 flipped), cin=0 -> syn=0x06, ue=1, dout=0x3, ue_cnt=1.
REQ-035 din=0, cin=0xFF -> syn=0xFF, ue=1. Also din=0, cin=0x80 -> syn=0x80, ce=1.
REQ-036 300 back-to-back CE words -> ce_cnt holds 255; cnt_clr with a CE in the same cycle -> 1; rst mid-stream -> out_vld stays 0 for 2 cycles after release.

Source files
------------

// File: rtl/sparc_exu_byp_eccchk.sv
// ---------------------------------------------------------------------------
// sparc_exu_byp_eccchk
// Two-stage 64/8 SEC-DED checker/corrector for bypass data.
//   Stage 1: registers din, in_vld and the syndrome (generated check ^ cin).
//   Stage 2: classifies the syndrome, corrects a single data-bit error and
//            registers dout/syn/ce/ue/out_vld.
//   Behind stage 2: saturating CE/UE counters and a first-error log.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   in_vld/din/cin  received word, its check bits and their valid
//   log_clr         clears the first-error log valid
//   cnt_clr         clears both error counters
//   out_vld/dout/syn/ce/ue   corrected word, syndrome and error flags
//   ce_cnt/ue_cnt   saturating error counters
//   log_vld/log_ue/log_syn   first-error log
//
// Code: data bit i sits at the (i+1)-th integer >= 3 that is not a power of
// two. Check bit k (k<7) is the XOR of data bits whose position has bit k
// set; check bit 7 is the XOR of data bits whose position has even popcount.
// ---------------------------------------------------------------------------
module sparc_exu_byp_eccchk (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    input  logic [63:0] din,
    input  logic [7:0]  cin,
    input  logic        log_clr,
    input  logic        cnt_clr,
    output logic        out_vld,
    output logic [63:0] dout,
    output logic [7:0]  syn,
    output logic        ce,
    output logic        ue,
    output logic [7:0]  ce_cnt,
    output logic [7:0]  ue_cnt,
    output logic        log_vld,
    output logic        log_ue,
    output logic [7:0]  log_syn
);

    // Codeword position of data bit i: i plus the count of skipped slots
    // (0, 1, 2 and the powers of two below the position).
    function automatic logic [6:0] data_pos(input logic [5:0] i);
        logic [6:0] iw;
        iw = {1'b0, i};
        if (i < 6'd1) begin
            data_pos = iw + 7'd3;
        end else if (i < 6'd4) begin
            data_pos = iw + 7'd4;
        end else if (i < 6'd11) begin
            data_pos = iw + 7'd5;
        end else if (i < 6'd26) begin
            data_pos = iw + 7'd6;
        end else if (i < 6'd57) begin
            data_pos = iw + 7'd7;
        end else begin
            data_pos = iw + 7'd8;
        end
    endfunction

    // Generated check bits for a data word.
    function automatic logic [7:0] gen_check(input logic [63:0] d);
        logic [7:0] p;
        logic [6:0] pos;
        p = 8'h00;
        for (int i = 0; i < 64; i++) begin
            pos = data_pos(i[5:0]);
            p[6:0] = p[6:0] ^ (pos & {7{d[i[5:0]]}});
            // even popcount <=> reduction XOR is zero
            if (!(^pos)) begin
                p[7] = p[7] ^ d[i[5:0]];
            end else begin
                p[7] = p[7];
            end
        end
        return p;
    endfunction

    // One-hot mask of the data bit addressed by a syndrome; zero when the
    // syndrome does not name a data position.
    function automatic logic [63:0] flip_mask(input logic [6:0] s);
        logic [63:0] m;
        m = 64'd0;
        for (int i = 0; i < 64; i++) begin
            m[i[5:0]] = (s == data_pos(i[5:0]));
        end
        return m;
    endfunction

    logic        vld1_r;
    logic [63:0] din1_r;
    logic [7:0]  syn1_r;
    logic [7:0]  syn_s;
    logic [63:0] mask_s;
    logic [63:0] flip_s;
    logic [63:0] dout_nxt_s;
    logic        ce_nxt_s;
    logic        ue_nxt_s;
    logic        pos_low_s;
    logic        ce_inc_s;
    logic        ue_inc_s;
    logic [7:0]  ce_cnt_nxt_s;
    logic [7:0]  ue_cnt_nxt_s;
    logic        log_ld_s;

    assign syn_s     = gen_check(din) ^ cin;
    assign mask_s    = flip_mask(syn1_r[6:0]);
    // s[6:0] is zero or a power of two: error confined to a check bit
    assign pos_low_s = ((syn1_r[6:0] & (syn1_r[6:0] - 7'd1)) == 7'd0);

    // Stage 1 pipeline register: data, valid and syndrome.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1_r <= 1'b0;
            din1_r <= 64'd0;
            syn1_r <= 8'h00;
        end else begin
            vld1_r <= in_vld;
            din1_r <= din;
            syn1_r <= syn_s;
        end
    end

    // Syndrome classification and single-bit correction.
    always_comb begin
        ce_nxt_s = 1'b0;
        ue_nxt_s = 1'b0;
        flip_s   = 64'd0;
        if (vld1_r && (syn1_r != 8'h00)) begin
            if (syn1_r[7]) begin
                if (pos_low_s || (mask_s != 64'd0)) begin
                    ce_nxt_s = 1'b1;
                    flip_s   = mask_s;
                end else begin
                    ue_nxt_s = 1'b1;
                end
            end else begin
                ue_nxt_s = 1'b1;
            end
        end else begin
            ce_nxt_s = 1'b0;
            ue_nxt_s = 1'b0;
        end
        dout_nxt_s = din1_r ^ flip_s;
    end

    // Stage 2 pipeline register: visible results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            dout    <= 64'd0;
            syn     <= 8'h00;
            ce      <= 1'b0;
            ue      <= 1'b0;
        end else begin
            out_vld <= vld1_r;
            dout    <= dout_nxt_s;
            syn     <= syn1_r;
            ce      <= ce_nxt_s;
            ue      <= ue_nxt_s;
        end
    end

    assign ce_inc_s = out_vld & ce;
    assign ue_inc_s = out_vld & ue;

    // Counter next-state: clear wins but still counts a coincident event.
    always_comb begin
        ce_cnt_nxt_s = ce_cnt;
        ue_cnt_nxt_s = ue_cnt;
        if (cnt_clr) begin
            ce_cnt_nxt_s = {7'd0, ce_inc_s};
            ue_cnt_nxt_s = {7'd0, ue_inc_s};
        end else begin
            if (ce_inc_s && (ce_cnt != 8'hFF)) begin
                ce_cnt_nxt_s = ce_cnt + 8'd1;
            end else begin
                ce_cnt_nxt_s = ce_cnt;
            end
            if (ue_inc_s && (ue_cnt != 8'hFF)) begin
                ue_cnt_nxt_s = ue_cnt + 8'd1;
            end else begin
                ue_cnt_nxt_s = ue_cnt;
            end
        end
    end

    // Error counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_cnt <= 8'h00;
            ue_cnt <= 8'h00;
        end else begin
            ce_cnt <= ce_cnt_nxt_s;
            ue_cnt <= ue_cnt_nxt_s;
        end
    end

    // A clear in the same cycle as an error re-arms and captures that error.
    assign log_ld_s = out_vld & (ce | ue) & (~log_vld | log_clr);

    // First-error log.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            log_vld <= 1'b0;
            log_ue  <= 1'b0;
            log_syn <= 8'h00;
        end else if (log_ld_s) begin
            log_vld <= 1'b1;
            log_ue  <= ue;
            log_syn <= syn;
        end else if (log_clr) begin
            log_vld <= 1'b0;
        end else begin
            log_vld <= log_vld;
        end
    end

endmodule

// File: tb/tb_sparc_exu_byp_eccchk.sv
// Scoreboard bench for sparc_exu_byp_eccchk: directed vectors, random
// traffic against a position-XOR reference model, counter saturation,
// clear/increment collision and mid-stream reset.
module tb_sparc_exu_byp_eccchk;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_vld = 1'b0;
    logic [63:0] din = 64'd0;
    logic [7:0]  cin = 8'h00;
    logic        log_clr = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        out_vld;
    logic [63:0] dout;
    logic [7:0]  syn;
    logic        ce;
    logic        ue;
    logic [7:0]  ce_cnt;
    logic [7:0]  ue_cnt;
    logic        log_vld;
    logic        log_ue;
    logic [7:0]  log_syn;

    sparc_exu_byp_eccchk dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .din(din), .cin(cin),
        .log_clr(log_clr), .cnt_clr(cnt_clr), .out_vld(out_vld),
        .dout(dout), .syn(syn), .ce(ce), .ue(ue), .ce_cnt(ce_cnt),
        .ue_cnt(ue_cnt), .log_vld(log_vld), .log_ue(log_ue),
        .log_syn(log_syn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] dout;
        logic [7:0]  syn;
        logic        ce;
        logic        ue;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [6:0]  pos_tab [64];
    int          m_ce_cnt = 0;
    int          m_ue_cnt = 0;
    logic        m_lv = 1'b0;
    logic        m_lue = 1'b0;
    logic [7:0]  m_lsyn = 8'h00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] d, input logic [7:0] s, input logic c, input logic u);
        exp_t e;
        e.dout = d; e.syn = s; e.ce = c; e.ue = u;
        return e;
    endfunction

    // Reference: syndrome = XOR of positions of set data bits ^ cin.
    function automatic exp_t model(input logic [63:0] d, input logic [7:0] c);
        exp_t e;
        logic [6:0] s;
        logic par;
        s = 7'd0; par = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (d[i]) begin
                s = s ^ pos_tab[i];
                if ($countones(pos_tab[i]) % 2 == 0) par = ~par;
            end
        end
        s = s ^ c[6:0];
        par = par ^ c[7];
        e = mk(d, {par, s}, 1'b0, 1'b0);
        if ({par, s} == 8'h00) begin
            e.ce = 1'b0;
        end else if (!par) begin
            e.ue = 1'b1;
        end else if (s == 7'd0 || $countones(s) == 1) begin
            e.ce = 1'b1;
        end else if (s > 7'd71) begin
            e.ue = 1'b1;
        end else begin
            e.ce = 1'b1;
            for (int i = 0; i < 64; i++)
                if (pos_tab[i] == s) e.dout[i] = ~d[i];
        end
        return e;
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic ce_ev, ue_ev;
        logic [7:0] ev_syn;
        if (rst) begin
            exp_q.delete();
            m_ce_cnt = 0; m_ue_cnt = 0;
            m_lv = 1'b0; m_lue = 1'b0; m_lsyn = 8'h00;
        end else begin
            chk("ce_cnt", ce_cnt, m_ce_cnt);
            chk("ue_cnt", ue_cnt, m_ue_cnt);
            chk("log_vld", log_vld, m_lv);
            chk("log_ue", log_ue, m_lue);
            chk("log_syn", log_syn, m_lsyn);
            ce_ev = 1'b0; ue_ev = 1'b0; ev_syn = 8'h00;
            if (out_vld) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_out_vld actual=1 expected=0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", dout, e.dout);
                    chk("syn", syn, e.syn);
                    chk("ce", ce, e.ce);
                    chk("ue", ue, e.ue);
                    ce_ev = e.ce; ue_ev = e.ue; ev_syn = e.syn;
                end
            end else begin
                chk("idle_ce", ce, 1'b0);
                chk("idle_ue", ue, 1'b0);
            end
            if (cnt_clr) m_ce_cnt = ce_ev ? 1 : 0;
            else if (ce_ev && m_ce_cnt < 255) m_ce_cnt++;
            if (cnt_clr) m_ue_cnt = ue_ev ? 1 : 0;
            else if (ue_ev && m_ue_cnt < 255) m_ue_cnt++;
            if ((ce_ev || ue_ev) && (!m_lv || log_clr)) begin
                m_lv = 1'b1; m_lue = ue_ev; m_lsyn = ev_syn;
            end else if (log_clr) begin
                m_lv = 1'b0;
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic [7:0] c, input exp_t e,
                        input logic cc, input logic lc);
        @(posedge clk); #1;
        in_vld = 1'b1; din = d; cin = c; cnt_clr = cc; log_clr = lc;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic cc);
        @(posedge clk); #1;
        in_vld = 1'b0; cnt_clr = cc; log_clr = 1'b0;
    endtask

    task automatic drain();
        int n;
        idle(1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic send_rand(input logic with_clr);
        logic [63:0] d;
        logic [7:0]  c;
        logic [7:0]  good;
        int kind;
        d = {$urandom, $urandom};
        good = model(d, 8'h00).syn;
        kind = $urandom_range(0, 5);
        case (kind)
            0: c = good;
            1: begin c = good; d[$urandom_range(0, 63)] ^= 1'b1; end
            2: begin c = good; c[$urandom_range(0, 7)] ^= 1'b1; end
            3: begin c = good; d[$urandom_range(0, 31)] ^= 1'b1; d[$urandom_range(32, 63)] ^= 1'b1; end
            4: c = 8'($urandom);
            default: begin c = good; c[$urandom_range(0, 7)] ^= 1'b1; d[$urandom_range(0, 63)] ^= 1'b1; end
        endcase
        send(d, c, model(d, c),
             with_clr && ($urandom_range(0, 15) == 0),
             with_clr && ($urandom_range(0, 15) == 0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_vld"}, out_vld, 1'b0);
        chk({tag, "_dout"}, dout, 64'd0);
        chk({tag, "_syn"}, syn, 8'h00);
        chk({tag, "_ce_ue"}, {ce, ue}, 2'b00);
        chk({tag, "_cnts"}, {ce_cnt, ue_cnt}, 16'h0000);
        chk({tag, "_log"}, {log_vld, log_ue, log_syn}, 10'd0);
    endtask

    initial begin
        int n;
        n = 0;
        for (int p = 3; p < 72; p++) begin
            if ($countones(p) != 1) begin
                pos_tab[n] = p[6:0];
                n++;
            end
        end

        #1 rst = 1'b1;
        #2 chk_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Directed vectors with constant expectations.
        send(64'd0, 8'h00, mk(64'd0, 8'h00, 1'b0, 1'b0), 1'b0, 1'b0);
        send(64'h1, 8'h00, mk(64'd0, 8'h83, 1'b1, 1'b0), 1'b0, 1'b0);
        drain();
        chk("dir_ce_cnt1", ce_cnt, 8'd1);
        chk("dir_log", {log_vld, log_ue, log_syn}, {1'b1, 1'b0, 8'h83});
        send(64'h8000000000000000, 8'h00, mk(64'd0, 8'hC7, 1'b1, 1'b0), 1'b0, 1'b0);
        send(64'h3, 8'h00, mk(64'h3, 8'h06, 1'b0, 1'b1), 1'b0, 1'b0);
        send(64'd0, 8'hFF, mk(64'd0, 8'hFF, 1'b0, 1'b1), 1'b0, 1'b0);
        send(64'd0, 8'h80, mk(64'd0, 8'h80, 1'b1, 1'b0), 1'b0, 1'b0);
        drain();
        chk("dir_cnts", {ce_cnt, ue_cnt}, {8'd3, 8'd2});
        chk("dir_log_kept", log_syn, 8'h83);

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) idle(1'b0);
            else send_rand(1'b1);
        end
        drain();

        // Saturation.
        idle(1'b1);
        for (int i = 0; i < 300; i++)
            send(64'h1, 8'h00, mk(64'd0, 8'h83, 1'b1, 1'b0), 1'b0, 1'b0);
        drain();
        chk("sat_ce_cnt", ce_cnt, 8'd255);

        // cnt_clr coinciding with a CE increment.
        send(64'h1, 8'h00, mk(64'd0, 8'h83, 1'b1, 1'b0), 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        #1 chk("clr_collide_ce_cnt", ce_cnt, 8'd1);

        // Mid-stream reset.
        for (int i = 0; i < 4; i++) send_rand(1'b0);
        @(posedge clk); #1;
        rst = 1'b1; in_vld = 1'b0;
        #1 chk_all_zero("mid_reset");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); chk("post_rst_vld0", out_vld, 1'b0);
        @(negedge clk); chk("post_rst_vld1", out_vld, 1'b0);
        for (int i = 0; i < 50; i++) send_rand(1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
